bus_sequencer: RTL and testbench

- Multi-cycle control sequencer for the shared 32-bit CPU bus.
- Steps one instruction through fetch and execute phases: drives the 5-bit bus source select, one-hot register load enables, the memory read handshake and the ALU opcode.
- Sits between the instruction register and the bus multiplexer/register file; one instruction in flight at a time.

---
 rtl/bus_seq_pkg.sv | 32 +++
 rtl/bus_seq_decode.sv | 16 +
 rtl/bus_sequencer.sv | 143 ++++++++++++++
 tb/tb_bus_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/bus_seq_pkg.sv
// bus_seq_pkg: shared types and constants for the bus sequencer.
// Holds the FSM state enum, bus source selects, opcodes and opcode-to-ALU mapping.
package bus_seq_pkg;
  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;
  localparam logic [4:0] SEL_R0     = 5'd0;
  localparam logic [4:0] SEL_HI     = 5'd16;
  localparam logic [4:0] SEL_LO     = 5'd17;
  localparam logic [4:0] SEL_ZHI    = 5'd18;
  localparam logic [4:0] SEL_ZLO    = 5'd19;
  localparam logic [4:0] SEL_PC     = 5'd20;
  localparam logic [4:0] SEL_MDR    = 5'd21;
  localparam logic [4:0] SEL_INPORT = 5'd22;
  localparam logic [4:0] SEL_C      = 5'd23;
  localparam logic [4:0] SEL_IDLE   = 5'd24;
  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_SHR  = 5'd4;
  localparam logic [4:0] OP_SHL  = 5'd5;
  localparam logic [4:0] OP_ROR  = 5'd6;
  localparam logic [4:0] OP_ROL  = 5'd7;
  localparam logic [4:0] OP_ADDI = 5'd8;
  localparam logic [4:0] OP_ANDI = 5'd9;
  localparam logic [4:0] OP_ORI  = 5'd10;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  // Immediates reuse the matching register-form ALU operation.
  function automatic logic [4:0] opcode_to_aluop(input logic [4:0] op);
    return op == OP_ADDI ? OP_ADD : op == OP_ANDI ? OP_AND : op == OP_ORI ? OP_OR : op;
  endfunction
endpackage

// File: rtl/bus_seq_decode.sv
// bus_seq_decode: combinational opcode classification.
// i_opcode: ir[31:27]; o_is_legal/o_is_imm/o_is_muldiv: class flags; o_alu_op: ALU code.
module bus_seq_decode
  import bus_seq_pkg::*;
(
  input  logic [4:0] i_opcode,
  output logic       o_is_legal,
  output logic       o_is_imm,
  output logic       o_is_muldiv,
  output logic [4:0] o_alu_op
);
  assign o_is_imm    = i_opcode inside {OP_ADDI, OP_ANDI, OP_ORI};
  assign o_is_muldiv = i_opcode inside {OP_MUL, OP_DIV};
  assign o_is_legal  = (i_opcode <= OP_ORI) || o_is_muldiv;
  assign o_alu_op    = opcode_to_aluop(i_opcode);
endmodule

// File: rtl/bus_sequencer.sv
// bus_sequencer: fetch/execute control sequencer for the shared 32-bit CPU bus.
// Inputs: i_clock, i_clear (async active-low), i_start, i_ir, i_mem_ready.
// Outputs: bus source select, register/datapath load enables, memory read, ALU op, busy/done/fault.
module bus_sequencer
  import bus_seq_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        i_clock,
  input  logic        i_clear,
  input  logic        i_start,
  input  logic [31:0] i_ir,
  input  logic        i_mem_ready,
  output logic [4:0]  o_bus_select,
  output logic [15:0] o_r_in,
  output logic        o_pc_in,
  output logic        o_ir_in,
  output logic        o_mar_in,
  output logic        o_mdr_in,
  output logic        o_y_in,
  output logic        o_z_in,
  output logic        o_hi_in,
  output logic        o_lo_in,
  output logic        o_inc_pc,
  output logic        o_mem_read,
  output logic [4:0]  o_alu_op,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_fault
);
  localparam int CW = $clog2(MEM_WAIT_MAX + 2);
  state_t        r_state;
  logic [CW-1:0] r_wait;
  logic          r_fault;
  logic          w_legal;
  logic          w_imm;
  logic          w_muldiv;
  logic [4:0]    w_alu_op;
  logic          w_timeout;
  logic          w_unused_ir;
  assign w_unused_ir = ^i_ir[14:0];
  bus_seq_decode u_decode (
    .i_opcode    (i_ir[31:27]),
    .o_is_legal  (w_legal),
    .o_is_imm    (w_imm),
    .o_is_muldiv (w_muldiv),
    .o_alu_op    (w_alu_op)
  );
  assign w_timeout = (MEM_WAIT_MAX != 0) && !i_mem_ready && (r_wait == CW'(MEM_WAIT_MAX - 1));
  always_ff @(posedge i_clock or negedge i_clear) begin
    if (!i_clear) begin
      r_state <= IDLE;
      r_wait  <= '0;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          r_state <= T0;
          r_fault <= 1'b0;
        end
        T0: begin
          r_state <= T1;
          r_wait  <= '0;
        end
        T1: if (i_mem_ready) r_state <= T2;
        else if (w_timeout) begin
          r_state <= IDLE;
          r_fault <= 1'b1;
        end
        // saturate so an unlimited wait never wraps back to the first-cycle value
        else r_wait <= r_wait + CW'(~&r_wait);
        T2: r_state <= T3;
        T3: if (w_legal) r_state <= T4;
        else begin
          r_state <= IDLE;
          r_fault <= 1'b1;
        end
        T4: r_state <= T5;
        T5: r_state <= w_muldiv ? T6 : IDLE;
        T6: r_state <= IDLE;
      endcase
    end
  end
  always_comb begin
    o_bus_select = SEL_IDLE;
    o_r_in       = '0;
    o_pc_in      = 1'b0;
    o_ir_in      = 1'b0;
    o_mar_in     = 1'b0;
    o_mdr_in     = 1'b0;
    o_y_in       = 1'b0;
    o_z_in       = 1'b0;
    o_hi_in      = 1'b0;
    o_lo_in      = 1'b0;
    o_inc_pc     = 1'b0;
    o_mem_read   = 1'b0;
    o_alu_op     = '0;
    o_done       = 1'b0;
    case (r_state)
      T0: begin
        o_bus_select = SEL_PC;
        o_mar_in     = 1'b1;
        o_inc_pc     = 1'b1;
        o_z_in       = 1'b1;
      end
      T1: begin
        o_bus_select = SEL_ZLO;
        o_pc_in      = r_wait == '0;
        o_mem_read   = 1'b1;
        o_mdr_in     = 1'b1;
      end
      T2: begin
        o_bus_select = SEL_MDR;
        o_ir_in      = 1'b1;
      end
      T3: begin
        o_bus_select = w_legal ? {1'b0, i_ir[22:19]} : SEL_IDLE;
        o_y_in       = w_legal;
        o_done       = !w_legal;
      end
      T4: begin
        o_bus_select = w_imm ? SEL_C : {1'b0, i_ir[18:15]};
        o_z_in       = 1'b1;
        o_alu_op     = w_alu_op;
      end
      T5: begin
        o_bus_select = SEL_ZLO;
        o_lo_in      = w_muldiv;
        o_r_in       = w_muldiv ? 16'd0 : 16'd1 << i_ir[26:23];
        o_done       = !w_muldiv;
      end
      T6: begin
        o_bus_select = SEL_ZHI;
        o_hi_in      = 1'b1;
        o_done       = 1'b1;
      end
      default: ;
    endcase
  end
  assign o_busy  = r_state != IDLE;
  // an illegal opcode is reported in the same cycle as its done pulse
  assign o_fault = r_fault | (r_state == T3 && !w_legal);
endmodule

// File: tb/tb_bus_sequencer.sv
// tb_bus_sequencer: randomized scoreboard bench for bus_sequencer.
module tb_bus_sequencer;
  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] ir = '0;
  logic [4:0]  bus_select, alu_op;
  logic [15:0] r_in;
  logic        pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, inc_pc, mem_read, busy, done, fault;
  always #5 clk = ~clk;
  bus_sequencer #(.MEM_WAIT_MAX(15)) dut (
    .i_clock(clk), .i_clear(clear), .i_start(start), .i_ir(ir), .i_mem_ready(mem_ready),
    .o_bus_select(bus_select), .o_r_in(r_in), .o_pc_in(pc_in), .o_ir_in(ir_in), .o_mar_in(mar_in),
    .o_mdr_in(mdr_in), .o_y_in(y_in), .o_z_in(z_in), .o_hi_in(hi_in), .o_lo_in(lo_in),
    .o_inc_pc(inc_pc), .o_mem_read(mem_read), .o_alu_op(alu_op), .o_busy(busy), .o_done(done),
    .o_fault(fault)
  );
  localparam logic [9:0] E_PC = 10'h200, E_IR = 10'h100, E_MAR = 10'h080, E_MDR = 10'h040, E_Y = 10'h020;
  localparam logic [9:0] E_Z = 10'h010, E_HI = 10'h008, E_LO = 10'h004, E_INC = 10'h002, E_RD = 10'h001;
  typedef logic [37:0] sig_t;
  function automatic sig_t mk(int sel, int rin, logic [9:0] en, int alu, bit dn, bit f);
    return {5'(sel), 16'(rin), en, 5'(alu), dn, f};
  endfunction
  sig_t act_sig;
  assign act_sig = {bus_select, r_in, {pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, inc_pc, mem_read},
                    alu_op, done, fault};
  sig_t exp_q[$];
  int   len_q[$];
  bit   flt_q[$];
  sig_t act[$];
  int   vectors = 0;
  int   errors = 0;
  bit   mon_en = 1'b1;
  int   m_len;
  bit   m_flt;
  sig_t m_exp;
  task automatic chk(string name, logic [63:0] got, logic [63:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask
  // Expected per-cycle trace of one instruction, built from the phase rules.
  task automatic model(input logic [4:0] op, input logic [3:0] ra, rb, rc, input int k, output int len);
    bit legal = (op <= 10) || op == 15 || op == 16;
    bit imm = op == 8 || op == 9 || op == 10;
    bit md = op == 15 || op == 16;
    int alu = op == 8 ? 0 : op == 9 ? 2 : op == 10 ? 3 : int'(op);
    int t1 = k >= 15 ? 15 : k + 1;
    bit f = 1'b0;
    len = 0;
    exp_q.push_back(mk(20, 0, E_MAR | E_INC | E_Z, 0, 0, 0)); len++;
    for (int i = 0; i < t1; i++) begin
      exp_q.push_back(mk(19, 0, (i == 0 ? E_PC : 10'h0) | E_RD | E_MDR, 0, 0, 0)); len++;
    end
    if (k >= 15) f = 1'b1;
    else begin
      exp_q.push_back(mk(21, 0, E_IR, 0, 0, 0)); len++;
      if (!legal) begin
        exp_q.push_back(mk(24, 0, 10'h0, 0, 1, 1)); len++;
        f = 1'b1;
      end else begin
        exp_q.push_back(mk(rb, 0, E_Y, 0, 0, 0)); len++;
        exp_q.push_back(mk(imm ? 23 : int'(rc), 0, E_Z, alu, 0, 0)); len++;
        if (md) begin
          exp_q.push_back(mk(19, 0, E_LO, 0, 0, 0)); len++;
          exp_q.push_back(mk(18, 0, E_HI, 0, 1, 0)); len++;
        end else begin
          exp_q.push_back(mk(19, 1 << ra, 10'h0, 0, 1, 0)); len++;
        end
      end
    end
    len_q.push_back(len);
    flt_q.push_back(f);
  endtask
  // k = cycles mem_ready stays low at the start of T1; start toggles randomly while busy.
  task automatic run(input logic [4:0] op, input logic [3:0] ra, rb, rc, input int k);
    int len;
    model(op, ra, rb, rc, k, len);
    ir = {op, ra, rb, rc, 15'($urandom)};
    start = 1'b1;
    for (int c = 1; c <= len; c++) begin
      @(posedge clk); #1;
      start = 1'($urandom % 2);
      mem_ready = c >= 2 + k;
    end
    @(posedge clk); #1;
    start = 1'b0;
    mem_ready = 1'($urandom % 2);
    repeat ($urandom % 3) begin
      @(posedge clk); #1;
    end
  endtask
  always @(negedge clk) begin
    if (mon_en && clear) begin
      if (busy) act.push_back(act_sig);
      else if (act.size() > 0) begin
        if (len_q.size() == 0) chk("unexpected_txn", act.size(), 0);
        else begin
          m_len = len_q.pop_front();
          m_flt = flt_q.pop_front();
          chk("length", act.size(), m_len);
          for (int i = 0; i < m_len; i++) begin
            m_exp = exp_q.pop_front();
            if (i < act.size()) chk($sformatf("cycle%0d", i + 1), act[i], m_exp);
          end
          chk("idle_after", act_sig, mk(24, 0, 10'h0, 0, 0, m_flt));
        end
        act.delete();
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  logic [4:0] legal_ops [13] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd15, 5'd16};
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_idle", act_sig, mk(24, 0, 10'h0, 0, 0, 0));
    chk("reset_busy", busy, 0);
    @(posedge clk); #1;
    clear = 1'b1;
    run(5'd0, 4'd1, 4'd2, 4'd3, 0);
    run(5'd8, 4'd4, 4'd5, 4'd0, 3);
    run(5'd15, 4'd6, 4'd7, 4'd0, 0);
    run(5'd31, 4'd1, 4'd2, 4'd3, 0);
    run(5'd1, 4'd9, 4'd10, 4'd11, 0);
    run(5'd3, 4'd2, 4'd3, 4'd4, 20);
    run(5'd16, 4'd0, 4'd1, 4'd2, 14);
    run(5'd2, 4'd0, 4'd15, 4'd14, 15);
    run(5'd10, 4'd15, 4'd1, 4'd1, 1);
    for (int n = 0; n < 60; n++)
      run($urandom % 4 != 0 ? legal_ops[$urandom % 13] : 5'($urandom % 32),
          4'($urandom), 4'($urandom), 4'($urandom),
          $urandom % 10 == 0 ? 15 + int'($urandom % 3) : int'($urandom % 4));
    @(negedge clk); #1;
    mon_en = 1'b0;
    ir = {5'd0, 4'd1, 4'd2, 4'd3, 15'd0};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mem_ready = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    chk("pre_reset_t4_sel", bus_select, 3);
    clear = 1'b0;
    #1;
    chk("clear_busy", busy, 0);
    chk("clear_idle", act_sig, mk(24, 0, 10'h0, 0, 0, 0));
    @(negedge clk); #2;
    clear = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_clear_done", {busy, done}, 0);
    end
    chk("queue_empty", len_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
